// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_pkg
//  Description : Shared LFSR polynomial constants and helpers for the
//                galois_lfsr generator and galois_lfsr_checker receiver.
//  Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam int c_lfsr_max_width = 32;

    // Coefficients of x^0..x^(W-1); x^W is implied.
    localparam logic [31:0] c_poly_w4  = 32'h0000_0009;
    localparam logic [31:0] c_poly_w8  = 32'h0000_0071;
    localparam logic [31:0] c_poly_w16 = 32'h0000_6801;
    localparam logic [31:0] c_poly_w32 = 32'h0040_0007;

    localparam logic [1:0] c_st_hunt   = 2'd0;
    localparam logic [1:0] c_st_verify = 2'd1;
    localparam logic [1:0] c_st_locked = 2'd2;

    function automatic logic [31:0] lfsr_default_poly(input int width);
        logic [31:0] poly;
        case (width)
            4:       poly = c_poly_w4;
            16:      poly = c_poly_w16;
            32:      poly = c_poly_w32;
            default: poly = c_poly_w8;
        endcase
        return poly;
    endfunction

    // history[0] is the oldest sequence bit; the result is the next bit.
    function automatic logic lfsr_next_bit(input logic [31:0] history,
                                           input logic [31:0] poly);
        return ^(history & poly);
    endfunction

    function automatic logic [5:0] popcount(input logic [31:0] value);
        logic [5:0] count;
        count = '0;
        for (int i = 0; i < 32; i++) begin
            count = count + {5'd0, value[i]};
        end
        return count;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_predict.sv
`default_nettype none
// ============================================================================
//  Module      : lfsr_predict
//  Description : Combinational N-step LFSR predictor. Emits the predicted bits
//                of one beat (oldest in the MSB) and the advanced history.
//  Revision    : 1.0 - initial release
// ============================================================================
module lfsr_predict
    import lfsr_pkg::*;
#(
    parameter int              LFSR_WIDTH                 = 8,
    parameter int              LFSR_OUTPUT_BITS_PER_CLOCK = 6,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY            = LFSR_WIDTH'(c_poly_w8)
) (
    input  logic [LFSR_WIDTH-1:0]                 i_hist,
    input  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] i_rx_bits,
    input  logic                                  i_free_run,
    output logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] o_pred_bits,
    output logic [LFSR_WIDTH-1:0]                 o_hist_next
);

    localparam int c_n = LFSR_OUTPUT_BITS_PER_CLOCK;

    logic [LFSR_WIDTH-1:0] w_h;
    logic                  w_bit;
    logic                  w_shift_in;

    // Free-run shifts in the prediction; load mode shifts in what was received.
    always_comb begin
        w_h         = i_hist;
        w_bit       = 1'b0;
        w_shift_in  = 1'b0;
        o_pred_bits = '0;
        for (int k = 0; k < c_n; k++) begin
            w_bit                = lfsr_next_bit(c_lfsr_max_width'(w_h),
                                                 c_lfsr_max_width'(LFSR_POLY));
            o_pred_bits[c_n-1-k] = w_bit;
            w_shift_in           = i_free_run ? w_bit : i_rx_bits[c_n-1-k];
            w_h                  = {w_shift_in, w_h[LFSR_WIDTH-1:1]};
        end
        o_hist_next = w_h;
    end

endmodule
`default_nettype wire

// File: rtl/galois_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : galois_lfsr_checker
//  Description : Self-synchronising PRBS receiver for the galois_lfsr stream;
//                counts bit errors once locked and relocks on sustained errors.
//  Revision    : 1.0 - initial release
// ============================================================================
module galois_lfsr_checker
    import lfsr_pkg::*;
#(
    parameter int                    LFSR_WIDTH                 = 8,
    parameter int                    LFSR_OUTPUT_BITS_PER_CLOCK = 6,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY                  = LFSR_WIDTH'(lfsr_default_poly(LFSR_WIDTH)),
    parameter int                    VERIFY_BEATS               = 4,
    parameter int                    LOSS_THRESH                = 3,
    parameter int                    CNT_WIDTH                  = 16
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    input  logic                                  clear,
    input  logic [LFSR_OUTPUT_BITS_PER_CLOCK-1:0] in_data,
    input  logic                                  in_valid,
    output logic                                  locked,
    output logic                                  err_pulse,
    output logic [CNT_WIDTH-1:0]                  err_count,
    output logic [CNT_WIDTH-1:0]                  bit_count
);

    localparam int c_n          = LFSR_OUTPUT_BITS_PER_CLOCK;
    localparam int c_pc_width   = $clog2(c_n + 1);
    localparam int c_fill_width = $clog2(LFSR_WIDTH + c_n + 1);
    localparam int c_ver_width  = $clog2(VERIFY_BEATS + 1);
    localparam int c_loss_width = $clog2(LOSS_THRESH + 1);

    localparam logic [c_fill_width-1:0] c_fill_step   = c_fill_width'(c_n);
    localparam logic [c_fill_width-1:0] c_fill_target = c_fill_width'(LFSR_WIDTH);
    localparam logic [c_ver_width-1:0]  c_verify_last = c_ver_width'(VERIFY_BEATS - 1);
    localparam logic [c_loss_width-1:0] c_loss_last   = c_loss_width'(LOSS_THRESH - 1);
    localparam logic [CNT_WIDTH:0]      c_bit_step    = (CNT_WIDTH+1)'(c_n);

    logic [1:0]              r_state;
    logic [1:0]              w_state_next;
    logic [LFSR_WIDTH-1:0]   r_hist;
    logic [c_fill_width-1:0] r_fill;
    logic [c_ver_width-1:0]  r_verify;
    logic [c_loss_width-1:0] r_loss;
    logic                    r_locked;
    logic                    r_err_pulse;
    logic [CNT_WIDTH-1:0]    r_err_count;
    logic [CNT_WIDTH-1:0]    r_bit_count;

    logic [c_n-1:0]          w_pred;
    logic [LFSR_WIDTH-1:0]   w_hist_next;
    logic [c_n-1:0]          w_diff;
    logic                    w_any_err;
    logic [c_pc_width-1:0]   w_mism;
    logic [c_fill_width-1:0] w_fill_sum;
    logic [CNT_WIDTH:0]      w_err_sum;
    logic [CNT_WIDTH:0]      w_bit_sum;
    logic                    w_err_event;
    logic                    w_count_en;

    lfsr_predict #(
        .LFSR_WIDTH                 (LFSR_WIDTH),
        .LFSR_OUTPUT_BITS_PER_CLOCK (c_n),
        .LFSR_POLY                  (LFSR_POLY)
    ) u_predict (
        .i_hist      (r_hist),
        .i_rx_bits   (in_data),
        .i_free_run  (r_state == c_st_locked),
        .o_pred_bits (w_pred),
        .o_hist_next (w_hist_next)
    );

    assign w_diff     = w_pred ^ in_data;
    assign w_any_err  = |w_diff;
    assign w_mism     = c_pc_width'(popcount(c_lfsr_max_width'(w_diff)));
    assign w_fill_sum = r_fill + c_fill_step;
    assign w_err_sum  = {1'b0, r_err_count} + (CNT_WIDTH+1)'(w_mism);
    assign w_bit_sum  = {1'b0, r_bit_count} + c_bit_step;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= c_st_hunt;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (in_valid) begin
            case (r_state)
                c_st_hunt: begin
                    if (w_fill_sum >= c_fill_target) begin
                        w_state_next = c_st_verify;
                    end
                end
                c_st_verify: begin
                    if (!w_any_err && (r_verify == c_verify_last)) begin
                        w_state_next = c_st_locked;
                    end
                end
                c_st_locked: begin
                    if (w_any_err && (r_loss == c_loss_last)) begin
                        w_state_next = c_st_hunt;
                    end
                end
                default: w_state_next = c_st_hunt;
            endcase
        end
    end

    always_comb begin
        w_err_event = 1'b0;
        w_count_en  = 1'b0;
        if (in_valid && (r_state == c_st_locked)) begin
            w_err_event = w_any_err;
            w_count_en  = !clear;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_hist      <= '0;
            r_fill      <= '0;
            r_verify    <= '0;
            r_loss      <= '0;
            r_locked    <= 1'b0;
            r_err_pulse <= 1'b0;
            r_err_count <= '0;
            r_bit_count <= '0;
        end else begin
            if (in_valid) begin
                r_hist <= w_hist_next;
                case (r_state)
                    c_st_hunt: begin
                        r_fill   <= w_fill_sum;
                        r_verify <= '0;
                        r_loss   <= '0;
                    end
                    c_st_verify: begin
                        r_verify <= w_any_err ? '0 : (r_verify + c_ver_width'(1));
                        r_loss   <= '0;
                    end
                    c_st_locked: begin
                        if (w_state_next == c_st_hunt) begin
                            r_fill   <= '0;
                            r_verify <= '0;
                            r_loss   <= '0;
                        end else begin
                            r_loss <= w_any_err ? (r_loss + c_loss_width'(1)) : '0;
                        end
                    end
                    default: begin
                        r_fill   <= '0;
                        r_verify <= '0;
                        r_loss   <= '0;
                    end
                endcase
            end

            r_locked    <= (w_state_next == c_st_locked);
            r_err_pulse <= w_err_event;

            // Clear outranks a coincident locked beat.
            if (clear) begin
                r_err_count <= '0;
                r_bit_count <= '0;
            end else if (w_count_en) begin
                r_err_count <= w_err_sum[CNT_WIDTH] ? '1 : w_err_sum[CNT_WIDTH-1:0];
                r_bit_count <= w_bit_sum[CNT_WIDTH] ? '1 : w_bit_sum[CNT_WIDTH-1:0];
            end
        end
    end

    assign locked    = r_locked;
    assign err_pulse = r_err_pulse;
    assign err_count = r_err_count;
    assign bit_count = r_bit_count;

endmodule
`default_nettype wire

// File: tb/tb_galois_lfsr_checker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_galois_lfsr_checker
//  Description : Directed self-checking bench for galois_lfsr_checker, with a
//                second instance using 4-bit counters for saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_galois_lfsr_checker;

    localparam logic [7:0] c_poly = 8'h71;

    logic        clk;
    logic        reset_n;
    logic        clear;
    logic [5:0]  in_data;
    logic        in_valid;

    logic        locked;
    logic        err_pulse;
    logic [15:0] err_count;
    logic [15:0] bit_count;

    logic        locked_s;
    logic        err_pulse_s;
    logic [3:0]  err_count_s;
    logic [3:0]  bit_count_s;

    logic [7:0]  gen_h;
    int          n_checks;
    int          n_pass;
    int          n_valid;
    int          n_after;
    logic [7:0]  gap_pat;
    logic        v;

    galois_lfsr_checker #(
        .LFSR_WIDTH(8), .LFSR_OUTPUT_BITS_PER_CLOCK(6), .LFSR_POLY(c_poly),
        .VERIFY_BEATS(4), .LOSS_THRESH(3), .CNT_WIDTH(16)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_data(in_data),
        .in_valid(in_valid), .locked(locked), .err_pulse(err_pulse),
        .err_count(err_count), .bit_count(bit_count)
    );

    galois_lfsr_checker #(
        .LFSR_WIDTH(8), .LFSR_OUTPUT_BITS_PER_CLOCK(6), .LFSR_POLY(c_poly),
        .VERIFY_BEATS(4), .LOSS_THRESH(3), .CNT_WIDTH(4)
    ) u_dut_sat (
        .clk(clk), .reset_n(reset_n), .clear(clear), .in_data(in_data),
        .in_valid(in_valid), .locked(locked_s), .err_pulse(err_pulse_s),
        .err_count(err_count_s), .bit_count(bit_count_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // One cycle; when valid, sends the next 6 sequence bits (oldest in MSB) XOR flip.
    task automatic beat(input logic valid, input logic [5:0] flip, input logic clr);
        logic [5:0] d;
        d = '0;
        @(negedge clk);
        if (valid) begin
            for (int k = 0; k < 6; k++) begin
                d[5-k] = gen_h[0];
                gen_h  = {^(gen_h & c_poly), gen_h[7:1]};
            end
            d = d ^ flip;
        end
        in_valid = valid;
        in_data  = d;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic clean_beats(input int n);
        for (int i = 0; i < n; i++) beat(1'b1, 6'd0, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_checks = 0;
        n_pass   = 0;
        gen_h    = 8'hA5;
        gap_pat  = 8'b0110_1011;
        reset_n  = 1'b0;
        clear    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_val("reset_locked",    32'(locked),    32'd0);
        check_val("reset_err_pulse", 32'(err_pulse), 32'd0);
        check_val("reset_err_count", 32'(err_count), 32'd0);
        check_val("reset_bit_count", 32'(bit_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // Acquisition: 2 fill beats + 4 verify beats.
        clean_beats(5);
        check_val("lock_after5", 32'(locked), 32'd0);
        clean_beats(1);
        check_val("lock_after6", 32'(locked), 32'd1);
        check_val("lock_bits0",  32'(bit_count), 32'd0);
        clean_beats(100);
        check_val("clean_err", 32'(err_count), 32'd0);
        check_val("clean_bits", 32'(bit_count), 32'd600);

        // Single flipped bit.
        beat(1'b1, 6'b001000, 1'b0);
        check_val("flip_pulse",  32'(err_pulse), 32'd1);
        check_val("flip_err",    32'(err_count), 32'd1);
        check_val("flip_locked", 32'(locked),    32'd1);
        check_val("flip_bits",   32'(bit_count), 32'd606);
        clean_beats(1);
        check_val("flip_pulse_end", 32'(err_pulse), 32'd0);
        check_val("flip_err_hold",  32'(err_count), 32'd1);

        // Clear leaves lock alone.
        beat(1'b0, 6'd0, 1'b1);
        check_val("clear_err",    32'(err_count), 32'd0);
        check_val("clear_bits",   32'(bit_count), 32'd0);
        check_val("clear_locked", 32'(locked),    32'd1);

        // Loss of lock on three fully inverted beats.
        beat(1'b1, 6'h3F, 1'b0);
        check_val("loss1_locked", 32'(locked),    32'd1);
        check_val("loss1_err",    32'(err_count), 32'd6);
        beat(1'b1, 6'h3F, 1'b0);
        beat(1'b1, 6'h3F, 1'b0);
        check_val("loss3_locked", 32'(locked),      32'd0);
        check_val("loss3_err",    32'(err_count),   32'd18);
        check_val("loss3_bits",   32'(bit_count),   32'd18);
        check_val("loss3_err_s",  32'(err_count_s), 32'd15);
        clean_beats(5);
        check_val("relock_after5", 32'(locked), 32'd0);
        clean_beats(1);
        check_val("relock_after6", 32'(locked),    32'd1);
        check_val("relock_err",    32'(err_count), 32'd18);

        // Valid gaps after a fresh reset.
        @(negedge clk);
        reset_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        n_valid = 0;
        n_after = 0;
        for (int i = 0; i < 48; i++) begin
            v = gap_pat[i % 8];
            beat(v, 6'd0, 1'b0);
            if (v) begin
                n_valid++;
                if (n_valid > 6) n_after++;
            end
        end
        check_val("gap_locked", 32'(locked),    32'd1);
        check_val("gap_err",    32'(err_count), 32'd0);
        check_val("gap_bits",   32'(bit_count), 32'(6 * n_after));

        // Saturation of the 4-bit instance.
        beat(1'b0, 6'd0, 1'b1);
        for (int i = 0; i < 20; i++) begin
            beat(1'b1, 6'b000001, 1'b0);
            beat(1'b1, 6'd0, 1'b0);
        end
        check_val("sat_err16",  32'(err_count),   32'd20);
        check_val("sat_err4",   32'(err_count_s), 32'd15);
        check_val("sat_bits4",  32'(bit_count_s), 32'd15);
        check_val("sat_locked", 32'(locked),      32'd1);
        beat(1'b1, 6'b000100, 1'b1);
        check_val("clrerr_err16", 32'(err_count),   32'd0);
        check_val("clrerr_err4",  32'(err_count_s), 32'd0);
        check_val("clrerr_bits",  32'(bit_count),   32'd0);
        check_val("clrerr_pulse", 32'(err_pulse_s), 32'd1);

        // Asynchronous reset while locked.
        beat(1'b1, 6'b000001, 1'b0);
        check_val("pre_rst_err", 32'(err_count), 32'd1);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check_val("arst_locked", 32'(locked),    32'd0);
        check_val("arst_err",    32'(err_count), 32'd0);
        check_val("arst_bits",   32'(bit_count), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        clean_beats(5);
        check_val("arst_relock5", 32'(locked), 32'd0);
        clean_beats(1);
        check_val("arst_relock6", 32'(locked), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
